// File: rtl/ma_decoder.sv
// ma_decoder: inverts an ORDER-tap moving sum y[n] back into the source
// sample stream x[n] = y[n] - y[n-1] + x[n-ORDER].
//
// Ports:
//   clk       - single clock, all state updates on the rising edge
//   rst       - synchronous active-high reset (highest priority)
//   in_valid  - in_data carries a moving-sum sample this cycle
//   in_data   - unsigned moving sum y[n] (INPUT_WIDTH bits)
//   resync    - single-cycle pulse: clears y_prev/history, returns to RUN
//   out_valid - out_data holds a freshly reconstructed sample
//   out_data  - reconstructed unsigned sample x[n] (OUTPUT_WIDTH bits)
//   fault     - high while the decoder sits in FAULT
//
// The range check assumes OUTPUT_WIDTH <= INPUT_WIDTH, so that the
// reconstructed value always fits in the INPUT_WIDTH+2 signed sum.
module ma_decoder #(
   parameter int unsigned INPUT_WIDTH  = 18,
   parameter int unsigned OUTPUT_WIDTH = 16,
   parameter int unsigned ORDER        = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [INPUT_WIDTH-1:0]  in_data,
   input  logic                    resync,
   output logic                    out_valid,
   output logic [OUTPUT_WIDTH-1:0] out_data,
   output logic                    fault
);

   localparam int unsigned SW = INPUT_WIDTH + 2;

   typedef enum logic {
      ST_RUN,
      ST_FAULT
   } state_e;

   state_e                              state_q, state_d;
   logic [INPUT_WIDTH-1:0]              y_prev_q, y_prev_d;
   // Shift register: index 0 is x[n-1], index ORDER-1 is x[n-ORDER].
   logic [ORDER-1:0][OUTPUT_WIDTH-1:0]  hist_q, hist_d;
   logic                                out_valid_q, out_valid_d;
   logic [OUTPUT_WIDTH-1:0]             out_data_q, out_data_d;

   logic signed [SW-1:0]                sum_s;
   logic                                in_range;

   // All operands zero-extended into SW signed bits, so no step can wrap.
   assign sum_s = $signed({2'b00, in_data})
                - $signed({2'b00, y_prev_q})
                + $signed({{(SW-OUTPUT_WIDTH){1'b0}}, hist_q[ORDER-1]});

   // Non-negative and no bits set above the output width.
   assign in_range = !sum_s[SW-1] && (sum_s[SW-2:OUTPUT_WIDTH] == '0);

   always_comb begin
      state_d     = state_q;
      y_prev_d    = y_prev_q;
      hist_d      = hist_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      if (resync) begin
         // Any sample arriving together with resync is dropped.
         state_d  = ST_RUN;
         y_prev_d = '0;
         hist_d   = '0;
      end else if (state_q == ST_RUN && in_valid) begin
         if (in_range) begin
            out_valid_d = 1'b1;
            out_data_d  = sum_s[OUTPUT_WIDTH-1:0];
            y_prev_d    = in_data;
            hist_d      = {hist_q[ORDER-2:0], sum_s[OUTPUT_WIDTH-1:0]};
         end else begin
            state_d = ST_FAULT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         y_prev_q    <= '0;
         hist_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         y_prev_q    <= y_prev_d;
         hist_q      <= hist_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign fault     = (state_q == ST_FAULT);

endmodule

// File: doc/ma_decoder.md
MA_DECODER -- requirements
Module: ma_decoder

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 18, width of the incoming moving-sum sample.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 16, width of the reconstructed sample.
REQ-003 SHALL have parameter ORDER, default 4, moving-sum window length, >=2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  in_data carries a moving-sum sample this cycle.
REQ-007 SHALL have port in_data  input  INPUT_WIDTH  unsigned moving sum y[n] of the last ORDER source samples.
REQ-008 SHALL have port resync  input  1  single-cycle pulse; clears history, leaves FAULT.
REQ-009 SHALL have port out_valid  output  1  out_data holds a reconstructed sample.
REQ-010 SHALL have port out_data  output  OUTPUT_WIDTH  reconstructed unsigned source sample x[n].
REQ-011 SHALL have port fault  output  1  high while in FAULT state.

Function
REQ-012 SHALL invert the moving sum: x[n] = y[n] - y[n-1] + x[n-ORDER], with y[-1] and x[<0] equal to 0 after reset/resync.
REQ-013 SHALL hold y_prev (INPUT_WIDTH) and an ORDER-deep history of past x values (OUTPUT_WIDTH each).
REQ-014 SHALL compute the sum in signed INPUT_WIDTH+2 bits; no intermediate wrap.
REQ-015 SHALL advance state only on cycles with in_valid=1; in_valid=0 cycles leave all state and out_data unchanged.
REQ-016 SHALL register the output: in_valid at edge k -> out_valid=1 and out_data=x[n] after edge k+1 (latency 1); out_valid=0 in the cycle after an in_valid=0 cycle.
REQ-017 SHALL implement a 2-state FSM: RUN (after reset) and FAULT.
REQ-018 RUN: if the computed sum lies in [0, 2^OUTPUT_WIDTH-1], output it, push it into history, load y_prev<=in_data.
REQ-019 RUN: if the sum is <0 or >2^OUTPUT_WIDTH-1, SHALL go to FAULT, output no sample (out_valid=0), not update history or y_prev.
REQ-020 FAULT: SHALL ignore in_valid/in_data, hold out_valid=0, fault=1.
REQ-021 resync=1 in any state SHALL clear y_prev and history to 0, set state RUN, and out_valid=0 the next cycle; the in_valid sample of that cycle is discarded.
REQ-022 resync and in_valid in the same cycle: resync wins (sample discarded).
REQ-023 History SHALL be a circular buffer or shift register; pointer wrap at ORDER-1 -> 0 without losing or duplicating an entry.
REQ-024 Back-to-back in_valid every cycle SHALL sustain one output per cycle.

Reset
REQ-025 rst=1 at a rising edge SHALL set: state RUN, y_prev=0, all history=0, out_valid=0, out_data=0, fault=0.
REQ-026 rst SHALL take priority over resync and in_valid; rst mid-stream discards all accumulated history.

Verification
REQ-027 Nominal: ORDER=4, in_valid continuous, in_data 1,3,6,10,14,18,22,26,21,15,8,0 -> out_data 1,2,3,4,5,6,7,8,0,0,0,0, each one cycle after its input, out_valid=1 throughout.
REQ-028 Gaps: same stream with in_valid=0 inserted every other cycle -> identical out_data sequence, out_valid high only in the cycles following valid inputs.
REQ-029 Fault: after reset, in_data 5 then 2 (x=-3) -> first output 5, then out_valid=0, fault=1; further inputs 7,9 produce no output; resync pulse -> fault=0; then in_data 4 -> out_data 4.
REQ-030 Overflow: OUTPUT_WIDTH=16, in_data 65535 then 131071 -> outputs 65535 then fault (65536 out of range).
REQ-031 Reset mid-stream: after in_data 1,3,6 apply rst one cycle, then in_data 4 -> out_data 4 (history cleared), out_valid=0 during and right after reset cycle.
REQ-032 Simultaneous: resync and in_valid (in_data 9) same cycle -> no output next cycle; next in_data 9 -> out_data 9.
